// File: rtl/storeunit.sv
// storeunit: SB/SH/SW store engine using read-modify-write on a word-only data memory
module storeunit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  controls,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        misaligned,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_waitrequest
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
   state_t state, nxt;
   logic [1:0]  ctl_q;
   logic [31:0] addr_q, wd_q, merged;
   logic        take, bad, rsv, done_d, mis_d;
   // request decode: a start is only taken in IDLE; rejected requests never touch memory
   always_comb begin
      take = state == IDLE && start;
      rsv = controls == 2'b11;
      bad = rsv || (controls == 2'b01 && addr[0]) || (controls == 2'b10 && addr[1:0] != 2'b00);
   end
   // lane merge of the captured store data into the word read back from memory
   always_comb begin
      merged = mem_rdata;
      if (ctl_q == 2'b01)
         merged = addr_q[1] ? {wd_q[15:0], mem_rdata[15:0]} : {mem_rdata[31:16], wd_q[15:0]};
      else
         for (int k = 0; k < 4; k++)
            if (addr_q[1:0] == k[1:0]) merged[8*k +: 8] = wd_q[7:0];
   end
   // next-state and completion decode
   always_comb begin
      nxt = state;
      done_d = 1'b0;
      mis_d = 1'b0;
      if (state == IDLE && take) begin
         nxt = bad ? IDLE : (controls == 2'b10 ? WRITE : READ);
         done_d = bad;
         mis_d = bad && !rsv;
      end else if (state == READ) begin
         nxt = mem_waitrequest ? READ : WRITE;
      end else if (state == WRITE) begin
         nxt = mem_waitrequest ? WRITE : IDLE;
         done_d = !mem_waitrequest;
      end
   end
   // state register; reset abandons any in-flight access without a done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= nxt;
   end
   // request capture, merged-word register and registered completion flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctl_q <= 2'b00;
         addr_q <= 32'h0;
         wd_q <= 32'h0;
         done <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         done <= done_d;
         misaligned <= mis_d;
         if (take) begin
            ctl_q <= controls;
            addr_q <= addr;
            wd_q <= wdata;
         end else if (state == READ && !mem_waitrequest) begin
            wd_q <= merged;
         end
      end
   end
   assign busy = state != IDLE;
   assign mem_read = state == READ;
   assign mem_write = state == WRITE;
   assign mem_addr = {addr_q[31:2], 2'b00};
   assign mem_wdata = wd_q;
endmodule

// File: tb/tb_storeunit.sv
// tb_storeunit: directed-vector bench for storeunit with hand-computed expectations
module tb_storeunit;
   logic        clk = 0, reset = 1, start = 0, mem_waitrequest = 0;
   logic [1:0]  controls = 0;
   logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
   logic        busy, done, misaligned, mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata;
   int nvec = 0, nerr = 0;

   storeunit dut (
      .clk(clk), .reset(reset), .start(start), .controls(controls), .addr(addr),
      .wdata(wdata), .busy(busy), .done(done), .misaligned(misaligned),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_waitrequest(mem_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
      controls = c; addr = a; wdata = d; start = 1;
      tick();
      start = 0;
   endtask

   task automatic sub_store(input string n, input logic [1:0] c, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rd, input logic [31:0] ew);
      mem_rdata = rd;
      issue(c, a, d);
      chk({n, " c1 read"}, mem_read, 1);
      chk({n, " c1 write"}, mem_write, 0);
      chk({n, " c1 busy"}, busy, 1);
      chk({n, " c1 addr"}, mem_addr, {a[31:2], 2'b00});
      tick();
      chk({n, " c2 write"}, mem_write, 1);
      chk({n, " c2 read"}, mem_read, 0);
      chk({n, " c2 wdata"}, mem_wdata, ew);
      tick();
      chk({n, " c3 done"}, done, 1);
      chk({n, " c3 busy"}, busy, 0);
      chk({n, " c3 mis"}, misaligned, 0);
      tick();
      chk({n, " c4 done"}, done, 0);
   endtask

   task automatic sw_store(input string n, input logic [31:0] a, input logic [31:0] d);
      issue(2'b10, a, d);
      chk({n, " c1 read"}, mem_read, 0);
      chk({n, " c1 write"}, mem_write, 1);
      chk({n, " c1 addr"}, mem_addr, a);
      chk({n, " c1 wdata"}, mem_wdata, d);
      tick();
      chk({n, " c2 done"}, done, 1);
      chk({n, " c2 read"}, mem_read, 0);
      chk({n, " c2 busy"}, busy, 0);
      tick();
      chk({n, " c3 done"}, done, 0);
   endtask

   task automatic reject(input string n, input logic [1:0] c, input logic [31:0] a, input logic m);
      issue(c, a, 32'h12345678);
      chk({n, " done"}, done, 1);
      chk({n, " mis"}, misaligned, m);
      chk({n, " busy"}, busy, 0);
      chk({n, " read"}, mem_read, 0);
      chk({n, " write"}, mem_write, 0);
      tick();
      chk({n, " done off"}, done, 0);
      chk({n, " mis off"}, misaligned, 0);
      chk({n, " write off"}, mem_write, 0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst mis", misaligned, 0);
      chk("rst read", mem_read, 0);
      chk("rst write", mem_write, 0);
      chk("rst addr", mem_addr, 0);
      chk("rst wdata", mem_wdata, 0);
      reset = 0;
      tick();

      sub_store("sb", 2'b00, 32'h00001002, 32'hAABBCCDD, 32'h11223344, 32'h11DD3344);
      sub_store("sh hi", 2'b01, 32'h00002002, 32'h0000BEEF, 32'hCAFEF00D, 32'hBEEFF00D);
      sub_store("sh lo", 2'b01, 32'h00002000, 32'h0000BEEF, 32'hCAFEF00D, 32'hCAFEBEEF);
      sub_store("sb b0", 2'b00, 32'h00001000, 32'h000000EE, 32'h11223344, 32'h112233EE);
      sub_store("sb b3", 2'b00, 32'h00001003, 32'h00000077, 32'h11223344, 32'h77223344);
      sw_store("sw", 32'h00003000, 32'hDEADBEEF);
      reject("mis sh", 2'b01, 32'h00002001, 1);
      reject("mis sw", 2'b10, 32'h00003002, 1);
      reject("rsv", 2'b11, 32'h00003000, 0);

      // SB with 3 wait cycles in READ and 2 in WRITE; a start during busy must be ignored
      mem_rdata = 32'hAABBCCDD;
      mem_waitrequest = 1;
      issue(2'b00, 32'h00004001, 32'h00000055);
      for (int c = 1; c <= 7; c++) begin
         mem_waitrequest = (c <= 3 || c == 5 || c == 6);
         if (c == 2) begin
            controls = 2'b10; addr = 32'h00005000; wdata = 32'h99999999; start = 1;
         end else start = 0;
         chk($sformatf("ws c%0d read", c), mem_read, c <= 4);
         chk($sformatf("ws c%0d write", c), mem_write, c >= 5);
         chk($sformatf("ws c%0d addr", c), mem_addr, 32'h00004000);
         chk($sformatf("ws c%0d busy", c), busy, 1);
         chk($sformatf("ws c%0d done", c), done, 0);
         if (c >= 5) chk($sformatf("ws c%0d wdata", c), mem_wdata, 32'hAABB55DD);
         tick();
      end
      start = 0;
      mem_waitrequest = 0;
      chk("ws c8 done", done, 1);
      chk("ws c8 busy", busy, 0);
      tick();
      chk("ws c9 done", done, 0);
      chk("ws c9 busy", busy, 0);
      chk("ws c9 write", mem_write, 0);

      // reset mid-WRITE
      mem_waitrequest = 1;
      issue(2'b10, 32'h00006000, 32'h0BADF00D);
      chk("rmw write", mem_write, 1);
      #2 reset = 1;
      #1;
      chk("rmw async write", mem_write, 0);
      chk("rmw async busy", busy, 0);
      tick();
      #2 reset = 0;
      mem_waitrequest = 0;
      tick();
      chk("rmw no done", done, 0);
      chk("rmw addr", mem_addr, 0);
      sw_store("sw after rst", 32'h00007000, 32'hDEADBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/storeunit.md
# storeunit

Store-side counterpart of the load path in the Harvard CPU. It executes SB, SH and SW against a word-only data memory that has no byte enables. Sub-word stores use a read-modify-write sequence: read the word, merge the byte or halfword lane, write the word back. The unit sits between the EX/MEM stage and the data-memory port, and holds the pipeline through `busy` until `done`.

## Interface
- No parameters; all widths fixed (32-bit data/address, little-endian byte lanes).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: store request; sampled only when `busy`=0.
- `controls` in 2: 00 SB, 01 SH, 10 SW, 11 reserved.
- `addr` in 32: byte address of the store.
- `wdata` in 32: rt register value. SB uses [7:0]; SH uses [15:0].
- `busy` out 1: high while a request is in progress; stalls the pipeline.
- `done` out 1: one-cycle completion pulse.
- `misaligned` out 1: valid with `done`; request rejected, no memory access.
- `mem_addr` out 32: word address, `{addr_q[31:2],2'b00}`.
- `mem_read` out 1: read request.
- `mem_write` out 1: write request.
- `mem_wdata` out 32: merged write word.
- `mem_rdata` in 32: read data, valid when `mem_read`=1 and `mem_waitrequest`=0.
- `mem_waitrequest` in 1: memory stall. Asserted, it holds the current request.

## Operation
- States: IDLE, READ, WRITE. `busy` = state≠IDLE.
- IDLE + `start`: capture `controls`, `addr`, `wdata` into `_q` registers.
  - SH with addr[0]=1, or SW with addr[1:0]≠00 → stay IDLE; next cycle `done`=1, `misaligned`=1.
  - Reserved 11 → stay IDLE; next cycle `done`=1, `misaligned`=0, no access.
  - SB, or aligned SH → READ.
  - Aligned SW → WRITE with `mem_wdata`=`wdata`; no read.
- READ: `mem_read`=1. On a cycle with `mem_waitrequest`=0, register the merged word and go to WRITE.
  - SB, k=addr[1:0]: bits [8k+7:8k] ← wdata[7:0]; other bytes from `mem_rdata`.
  - SH, h=addr[1]: bits [16h+15:16h] ← wdata[15:0]; other half from `mem_rdata`.
- WRITE: `mem_write`=1, `mem_wdata` = merged word (or `wdata` for SW). On a cycle with `mem_waitrequest`=0, go to IDLE and pulse `done` the next cycle.
- `mem_read` and `mem_write` are never high together.
- `mem_addr`, `mem_wdata` and the request strobes stay stable while `mem_waitrequest`=1.
- `start` while `busy`=1 is ignored; the pipeline must hold it.
- `start` in the same cycle as `done` is accepted, because the state is already IDLE.

## Timing
- Reset values: state IDLE. `busy`, `done`, `misaligned`, `mem_read`, `mem_write` = 0. `mem_addr`, `mem_wdata` = 0.
- Reset mid-operation: strobes drop immediately (async), no `done` is produced, and any partial write is abandoned.
- All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- Latency with zero wait states, `start` at cycle 0:
  - SB/SH: READ c1, WRITE c2, `done` c3.
  - SW: WRITE c1, `done` c2.
  - Misaligned or reserved: `done` c1.
- Each wait cycle adds exactly one cycle to the state it occurs in.
- `done` and `misaligned` are high for exactly one cycle, with `busy`=0 in that cycle.

## Test plan
- SB: addr 0x00001002, wdata 0xAABBCCDD, memory word 0x11223344. → c1 read at 0x00001000; c2 write 0x11DD3344; c3 `done`.
- SH: addr 0x00002002, wdata 0x0000BEEF, memory word 0xCAFEF00D. → write 0xBEEFF00D to 0x00002000; `done` c3. Repeat at addr 0x00002000 → 0xCAFEBEEF.
- SW: addr 0x00003000, wdata 0xDEADBEEF. → no `mem_read` ever; c1 write 0xDEADBEEF; c2 `done`.
- Misaligned SH at addr 0x00002001, and SW at 0x00003002. → c1 `done`=1 and `misaligned`=1; `mem_read` and `mem_write` stay 0.
- Wait states: SB with `mem_waitrequest`=1 for 3 cycles in READ and 2 cycles in WRITE. → address, strobes and `mem_wdata` stable throughout; `done` at c8. A `start` pulse during `busy` is ignored.
- Reset asserted mid-WRITE. → `mem_write` and `busy` fall asynchronously; no `done`. A new SW issued after reset release completes normally in 2 cycles.
